// File: rtl/serial_word_capture_if.sv
// Serial-bit input and captured-word output bundle for serial_word_capture.
interface serial_word_capture_if #(
   parameter int unsigned WORD_WIDTH = 4
);
   logic                  i_bit_in;
   logic                  i_bit_en;
   logic                  i_out_ready;
   logic [WORD_WIDTH-1:0] o_word_out;
   logic                  o_out_valid;
   logic                  o_parity_err;
   logic                  o_framing_err;
   logic                  o_overrun;
   logic                  o_busy;

   // Capture block side: consumes serial bits, produces words
   modport slave (
      input  i_bit_in, i_bit_en, i_out_ready,
      output o_word_out, o_out_valid, o_parity_err, o_framing_err, o_overrun, o_busy
   );

   // Environment side: drives serial bits, consumes words
   modport master (
      output i_bit_in, i_bit_en, i_out_ready,
      input  o_word_out, o_out_valid, o_parity_err, o_framing_err, o_overrun, o_busy
   );
endinterface

// File: rtl/serial_word_capture.sv
// Recovers start/data/parity/stop frames from a serial bit stream and
// presents each good word on a valid/ready output with error flags.
module serial_word_capture #(
   parameter int unsigned WORD_WIDTH = 4,
   parameter int unsigned MSB_FIRST  = 1,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                     clk,
   input  logic                     sclr,
   serial_word_capture_if.slave     bus
);

   localparam int unsigned CNT_W = $clog2(WORD_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [WORD_WIDTH-1:0] r_asm;
   logic                  r_pbit;
   logic [WORD_WIDTH-1:0] r_word;
   logic                  r_valid;
   logic                  r_perr;
   logic                  r_ferr;
   logic                  r_ovr;
   logic                  r_busy;

   state_t                w_state_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [WORD_WIDTH-1:0] w_asm_nxt;
   logic                  w_pbit_nxt;
   logic [WORD_WIDTH-1:0] w_word_nxt;
   logic                  w_valid_nxt;
   logic                  w_perr_nxt;
   logic                  w_ferr_nxt;
   logic                  w_ovr_nxt;
   logic [WORD_WIDTH-1:0] w_shift;
   logic                  w_perr_calc;

   // Next assembly value and parity verdict for the word being assembled
   always_comb begin
      w_shift = (MSB_FIRST != 0) ? {r_asm[WORD_WIDTH-2:0], bus.i_bit_in}
                                 : {bus.i_bit_in, r_asm[WORD_WIDTH-1:1]};
      w_perr_calc = (PARITY_EN != 0) && (((^r_asm) ^ r_pbit) != 1'(PARITY_ODD));
   end

   // Frame FSM next state, output-slot handshake and delivery
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_asm_nxt   = r_asm;
      w_pbit_nxt  = r_pbit;
      w_word_nxt  = r_word;
      w_valid_nxt = r_valid;
      w_perr_nxt  = r_perr;
      w_ferr_nxt  = 1'b0;
      w_ovr_nxt   = r_ovr;

      if (r_valid && bus.i_out_ready) begin
         w_valid_nxt = 1'b0;
      end

      if (bus.i_bit_en) begin
         case (r_state)
            ST_IDLE: begin
               if (!bus.i_bit_in) begin
                  w_state_nxt = ST_DATA;
                  w_cnt_nxt   = '0;
               end
            end
            ST_DATA: begin
               w_asm_nxt = w_shift;
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (r_cnt == LAST_BIT) begin
                  w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end
            end
            ST_PARITY: begin
               w_pbit_nxt  = bus.i_bit_in;
               w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
               w_state_nxt = ST_IDLE;
               if (bus.i_bit_in) begin
                  // A slot being accepted on this same edge counts as free
                  if (!r_valid || bus.i_out_ready) begin
                     w_word_nxt  = r_asm;
                     w_perr_nxt  = w_perr_calc;
                     w_valid_nxt = 1'b1;
                  end else begin
                     w_ovr_nxt = 1'b1;
                  end
               end else begin
                  w_ferr_nxt = 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State and output registers with synchronous clear
   always_ff @(posedge clk) begin
      if (sclr) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_asm   <= '0;
         r_pbit  <= 1'b0;
         r_word  <= '0;
         r_valid <= 1'b0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_asm   <= w_asm_nxt;
         r_pbit  <= w_pbit_nxt;
         r_word  <= w_word_nxt;
         r_valid <= w_valid_nxt;
         r_perr  <= w_perr_nxt;
         r_ferr  <= w_ferr_nxt;
         r_ovr   <= w_ovr_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

   assign bus.o_word_out    = r_word;
   assign bus.o_out_valid   = r_valid;
   assign bus.o_parity_err  = r_perr;
   assign bus.o_framing_err = r_ferr;
   assign bus.o_overrun     = r_ovr;
   assign bus.o_busy        = r_busy;

endmodule
